frame_sync_deserializer: RTL and testbench
==========================================

FRAME_SYNC_DESERIALIZER -- requirements
Module: frame_sync_deserializer

Interface
REQ-001 Parameter SYNC_WORD, 8'hE5, frame sync pattern, transmitted MSB-first ahead of each payload.
REQ-002 Parameter N_SAMPLES, 4, number of 8-bit payload samples per frame; frame length = 8 + 8*N_SAMPLES bits.
REQ-003 Parameter CONFIRM_N, 1, consecutive further sync matches required in VERIFY before lock.
REQ-004 Parameter MISS_LIMIT, 2, consecutive sync misses in LOCKED that force loss of lock.
REQ-005 clk  in  1  block clock, all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 serial_in  in  1  decoded bit stream from Viterbi decoder, MSB-first.
REQ-008 bit_valid  in  1  qualifies serial_in; bits are consumed only when high.
REQ-009 resync  in  1  synchronous request to drop lock and return to HUNT.
REQ-010 parallel_data  out  8 signed  last completed payload sample.
REQ-011 data_valid  out  1  one-cycle pulse per emitted sample.
REQ-012 frame_start  out  1  one-cycle pulse on each accepted sync word in LOCKED.
REQ-013 locked  out  1  high while state is LOCKED.
REQ-014 sync_err_cnt  out  8  saturating count of sync misses seen in LOCKED.

Function
REQ-015 The block SHALL keep an 8-bit shift register updated only on bit_valid cycles (new bit into LSB).
REQ-016 States SHALL be HUNT, VERIFY, LOCKED; a bit counter SHALL track position 0..(8+8*N_SAMPLES-1) within the frame, wrapping to 0 after the last payload bit.
REQ-017 HUNT: on each valid bit, if the shift register including the new bit equals SYNC_WORD, go to VERIFY with the counter set to position 8 (first payload bit); otherwise stay.
REQ-018 VERIFY: payload SHALL be counted but not emitted; at position 7 the shift register SHALL be compared to SYNC_WORD; a match increments confirm count and, at CONFIRM_N, enters LOCKED; any mismatch returns to HUNT.
REQ-019 LOCKED: at each position 15, 23, ... (end of each payload byte) the byte SHALL be registered to parallel_data with data_valid high the following cycle (latency 1 clk after the accepting edge).
REQ-020 LOCKED sync check at position 7: match clears miss count and pulses frame_start; mismatch increments miss count and sync_err_cnt (saturating at 8'hFF), payload of that frame is still emitted (flywheel).
REQ-021 When miss count reaches MISS_LIMIT, the block SHALL enter HUNT, deassert locked the next cycle, and emit no further samples.
REQ-022 bit_valid low SHALL freeze the shift register, counter and state; gaps of any length SHALL not alter output values.
REQ-023 resync high SHALL force HUNT, clear counters (not sync_err_cnt) and suppress data_valid that cycle; resync has priority over a simultaneous valid bit, which is discarded.
REQ-024 data_valid and frame_start SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-025 While reset is high: state HUNT, shift register, bit counter, confirm and miss counts, parallel_data, data_valid, frame_start, locked, sync_err_cnt all 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately; no partial sample SHALL be emitted after release.

Structure
REQ-027 Package frame_sync_pkg SHALL hold the state enum, default SYNC_WORD, sample width (8) and counter width constants.
REQ-028 One sub-module, sync_correlator (shift register plus SYNC_WORD compare, output match), SHALL be instantiated.

Verification
REQ-029 Three clean frames E5|01 80 7F FF, bit_valid constant high -> locked rises after frame-2 sync; samples 01,80,7F,FF emitted once from frame 2; frame_start pulses at frames 2 and 3.
REQ-030 Locked stream, frame-4 sync replaced by 8'h00 -> locked stays high, sync_err_cnt=1, frame-4 payload still emitted, frame_start absent for frame 4.
REQ-031 Locked stream, two consecutive bad syncs -> locked low after second miss, sync_err_cnt=2, no data_valid afterwards until relock.
REQ-032 HUNT, random bits containing E5 then payload and non-E5 at next sync slot -> return to HUNT, zero data_valid pulses, locked never high.
REQ-033 Stream of REQ-029 with bit_valid high every third cycle -> identical sample values and order.
REQ-034 Reset pulsed mid-payload of a locked frame, then resync high alongside a valid bit -> all outputs 0, state HUNT, bit discarded, relock after two further clean frames.

Source files
------------

// File: rtl/frame_sync_pkg.sv
// Shared types and constants for the frame-sync deserializer.
package frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]  DEFAULT_SYNC_WORD = 8'hE5;
  localparam int unsigned SAMPLE_W          = 8;
  localparam int unsigned DEFAULT_N_SAMPLES = 4;
  localparam int unsigned CTR_W             = 8;

  function automatic int unsigned frame_bits(input int unsigned n_samples);
    return SAMPLE_W + SAMPLE_W * n_samples;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n_samples);
    return $clog2(frame_bits(n_samples));
  endfunction

endpackage

// File: rtl/sync_correlator.sv
// Serial shift register with a sync-word compare against the window that includes the incoming bit.
module sync_correlator
  import frame_sync_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                shift_en,
  input  logic                bit_in,
  output logic [SAMPLE_W-1:0] window,
  output logic                match
);

  // Only seven history bits are kept: every decision looks at history plus the bit arriving now.
  logic [SAMPLE_W-2:0] history;

  assign window = {history, bit_in};
  assign match  = (window == SYNC_WORD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      history <= '0;
    end else if (clear) begin
      history <= '0;
    end else if (shift_en) begin
      history <= window[SAMPLE_W-2:0];
    end
  end

endmodule

// File: rtl/frame_sync_deserializer.sv
// Frame synchroniser: hunts for the sync word, verifies it, then deserializes payload samples while locked.
module frame_sync_deserializer
  import frame_sync_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
  parameter int unsigned         N_SAMPLES  = DEFAULT_N_SAMPLES,
  parameter int unsigned         CONFIRM_N  = 1,
  parameter int unsigned         MISS_LIMIT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       serial_in,
  input  logic                       bit_valid,
  input  logic                       resync,
  output logic signed [SAMPLE_W-1:0] parallel_data,
  output logic                       data_valid,
  output logic                       frame_start,
  output logic                       locked,
  output logic [CTR_W-1:0]           sync_err_cnt
);

  localparam int unsigned     FRAME_BITS   = frame_bits(N_SAMPLES);
  localparam int unsigned     CW           = cnt_width(N_SAMPLES);
  localparam logic [CW-1:0]   POS_SYNC_END = CW'(SAMPLE_W - 1);
  localparam logic [CW-1:0]   POS_PAYLOAD  = CW'(SAMPLE_W);
  localparam logic [CW-1:0]   POS_FIRST_BE = CW'(2 * SAMPLE_W - 1);
  localparam logic [CW-1:0]   POS_LAST     = CW'(FRAME_BITS - 1);
  localparam logic [CTR_W-1:0] CONFIRM_TGT = CTR_W'(CONFIRM_N);
  localparam logic [CTR_W-1:0] MISS_TGT    = CTR_W'(MISS_LIMIT);

  state_t              state;
  logic [CW-1:0]       pos;
  logic [CW-1:0]       next_pos;
  logic [CTR_W-1:0]    confirm_cnt;
  logic [CTR_W-1:0]    miss_cnt;
  logic [SAMPLE_W-1:0] window;
  logic                match;
  logic                byte_end;

  sync_correlator #(
    .SYNC_WORD(SYNC_WORD)
  ) u_corr (
    .clk     (clk),
    .reset   (reset),
    .clear   (resync),
    .shift_en(bit_valid & ~resync),
    .bit_in  (serial_in),
    .window  (window),
    .match   (match)
  );

  assign next_pos = (pos == POS_LAST) ? '0 : pos + CW'(1);
  assign byte_end = (pos >= POS_FIRST_BE) && (pos[2:0] == 3'b111);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= HUNT;
      pos           <= '0;
      confirm_cnt   <= '0;
      miss_cnt      <= '0;
      parallel_data <= '0;
      data_valid    <= 1'b0;
      frame_start   <= 1'b0;
      locked        <= 1'b0;
      sync_err_cnt  <= '0;
    end else begin
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      if (resync) begin
        state       <= HUNT;
        pos         <= '0;
        confirm_cnt <= '0;
        miss_cnt    <= '0;
        locked      <= 1'b0;
      end else if (bit_valid) begin
        unique case (state)
          HUNT: begin
            if (match) begin
              state <= VERIFY;
              pos   <= POS_PAYLOAD;
            end
          end
          VERIFY: begin
            if (pos != POS_SYNC_END) begin
              pos <= next_pos;
            end else if (!match) begin
              state       <= HUNT;
              pos         <= '0;
              confirm_cnt <= '0;
            end else if (confirm_cnt + CTR_W'(1) >= CONFIRM_TGT) begin
              state       <= LOCKED;
              locked      <= 1'b1;
              frame_start <= 1'b1;
              confirm_cnt <= '0;
              pos         <= next_pos;
            end else begin
              confirm_cnt <= confirm_cnt + CTR_W'(1);
              pos         <= next_pos;
            end
          end
          LOCKED: begin
            if (pos != POS_SYNC_END) begin
              if (byte_end) begin
                parallel_data <= $signed(window);
                data_valid    <= 1'b1;
              end
              pos <= next_pos;
            end else if (match) begin
              miss_cnt    <= '0;
              frame_start <= 1'b1;
              pos         <= next_pos;
            end else begin
              // A missed sync still lets the payload through until the miss limit is hit.
              if (sync_err_cnt != '1) sync_err_cnt <= sync_err_cnt + CTR_W'(1);
              if (miss_cnt + CTR_W'(1) >= MISS_TGT) begin
                state    <= HUNT;
                locked   <= 1'b0;
                pos      <= '0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + CTR_W'(1);
                pos      <= next_pos;
              end
            end
          end
          default: begin
            state <= HUNT;
            pos   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_sync_deserializer.sv
// Self-checking bench for frame_sync_deserializer with a bit-stream reference model.
module tb_frame_sync_deserializer;

  localparam int          FB   = 40;
  localparam logic [7:0]  SYNC = 8'hE5;
  localparam logic [31:0] PAY  = 32'h01807FFF;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              serial_in = 1'b0;
  logic              bit_valid = 1'b0;
  logic              resync = 1'b0;
  logic signed [7:0] parallel_data;
  logic              data_valid;
  logic              frame_start;
  logic              locked;
  logic [7:0]        sync_err_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  frame_sync_deserializer #(
    .SYNC_WORD (8'hE5),
    .N_SAMPLES (4),
    .CONFIRM_N (1),
    .MISS_LIMIT(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .resync       (resync),
    .parallel_data(parallel_data),
    .data_valid   (data_valid),
    .frame_start  (frame_start),
    .locked       (locked),
    .sync_err_cnt (sync_err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: frame position of the next bit plus a history of the last eight bits.
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;
  int         m_mode, m_pos, m_conf, m_miss, m_emit;
  logic [7:0] m_err, m_pd;
  bit         m_dv, m_fs, m_locked;
  bit         hist[$];

  logic [7:0] cap_q[$];
  bit         stim[$];
  int         fs_seen, vbit_idx, lock_rise_at, lock_fall_at;
  bit         prev_locked;

  task automatic model_reset();
    m_mode = M_HUNT; m_pos = 0; m_conf = 0; m_miss = 0; m_emit = 0;
    m_err = 8'h00; m_pd = 8'h00; m_dv = 0; m_fs = 0; m_locked = 0;
    hist.delete();
  endtask

  task automatic model_step(input bit b, input bit v, input bit rs);
    logic [7:0] w;
    m_dv = 0; m_fs = 0;
    if (rs) begin
      m_mode = M_HUNT; m_pos = 0; m_conf = 0; m_miss = 0; m_locked = 0;
      hist.delete();
      return;
    end
    if (!v) return;
    hist.push_back(b);
    if (hist.size() > 8) void'(hist.pop_front());
    w = 8'h00;
    foreach (hist[i]) w = {w[6:0], hist[i]};
    if (m_mode == M_HUNT) begin
      if (w == SYNC) begin m_mode = M_VERIFY; m_pos = 8; end
      return;
    end
    if (m_pos == 7) begin
      if (m_mode == M_VERIFY) begin
        if (w != SYNC) begin m_mode = M_HUNT; m_pos = 0; m_conf = 0; return; end
        m_conf++;
        if (m_conf >= 1) begin m_mode = M_LOCKED; m_locked = 1; m_fs = 1; m_conf = 0; end
      end else if (w == SYNC) begin
        m_miss = 0; m_fs = 1;
      end else begin
        m_miss++;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
        if (m_miss >= 2) begin m_mode = M_HUNT; m_locked = 0; m_pos = 0; m_miss = 0; return; end
      end
    end else if (m_mode == M_LOCKED && m_pos % 8 == 7) begin
      m_pd = w; m_dv = 1; m_emit++;
    end
    m_pos = (m_pos + 1) % FB;
  endtask

  task automatic add_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) stim.push_back(v[i]);
  endtask

  task automatic add_frame(input logic [7:0] s, input logic [31:0] p);
    add_byte(s); add_byte(p[31:24]); add_byte(p[23:16]); add_byte(p[15:8]); add_byte(p[7:0]);
  endtask

  task automatic clear_obs();
    cap_q.delete(); fs_seen = 0; vbit_idx = 0;
    lock_rise_at = -1; lock_fall_at = -1; prev_locked = 0;
  endtask

  task automatic tick(input bit b, input bit v, input bit rs);
    @(negedge clk);
    serial_in = b; bit_valid = v; resync = rs;
    @(posedge clk);
    model_step(b, v, rs);
    #1;
    if (v && !rs) vbit_idx++;
    if (data_valid === 1'b1) cap_q.push_back(parallel_data);
    if (frame_start === 1'b1) fs_seen++;
    if (locked === 1'b1 && !prev_locked && lock_rise_at < 0) lock_rise_at = vbit_idx - 1;
    if (locked !== 1'b1 && prev_locked && lock_fall_at < 0) lock_fall_at = vbit_idx - 1;
    prev_locked = (locked === 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; serial_in = 0; bit_valid = 0; resync = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    clear_obs();
    stim.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    serial_in = 1; bit_valid = 1; resync = 0;
    reset = 1;
    model_reset();
    @(posedge clk); #1;
    tests_run++; if (parallel_data !== 8'sh00) begin tests_failed++; $display("FAIL reset_pd: got %h want 00", parallel_data); end
    tests_run++; if (data_valid !== 1'b0)    begin tests_failed++; $display("FAIL reset_dv: got %b want 0", data_valid); end
    tests_run++; if (frame_start !== 1'b0)   begin tests_failed++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    tests_run++; if (locked !== 1'b0)        begin tests_failed++; $display("FAIL reset_locked: got %b want 0", locked); end
    tests_run++; if (sync_err_cnt !== 8'h00) begin tests_failed++; $display("FAIL reset_err: got %h want 00", sync_err_cnt); end
    do_reset();
  endtask

  task automatic test_clean_lock();
    logic [7:0] exp_s;
    do_reset();
    for (int f = 0; f < 3; f++) add_frame(SYNC, PAY);
    foreach (stim[i]) begin
      tick(stim[i], 1'b1, 1'b0);
      tests_run++;
      if (data_valid !== m_dv || frame_start !== m_fs || locked !== m_locked ||
          parallel_data !== m_pd || sync_err_cnt !== m_err) begin
        tests_failed++;
        $display("FAIL clean_lock bit %0d: dv=%b fs=%b lk=%b pd=%h err=%h want dv=%b fs=%b lk=%b pd=%h err=%h",
                 i, data_valid, frame_start, locked, parallel_data, sync_err_cnt, m_dv, m_fs, m_locked, m_pd, m_err);
      end
    end
    tests_run++; if (lock_rise_at != 47) begin tests_failed++; $display("FAIL clean_lock_rise: got bit %0d want 47", lock_rise_at); end
    tests_run++; if (fs_seen != 2) begin tests_failed++; $display("FAIL clean_lock_fs_count: got %0d want 2", fs_seen); end
    tests_run++; if (cap_q.size() != 8) begin tests_failed++; $display("FAIL clean_lock_count: got %0d want 8", cap_q.size()); end
    for (int k = 0; k < 8 && k < cap_q.size(); k++) begin
      exp_s = PAY[31 - 8*(k%4) -: 8];
      tests_run++;
      if (cap_q[k] !== exp_s) begin tests_failed++; $display("FAIL clean_lock_sample %0d: got %h want %h", k, cap_q[k], exp_s); end
    end
  endtask

  task automatic test_flywheel();
    logic [31:0] p4, p5;
    do_reset();
    p4 = $urandom; p5 = $urandom;
    for (int f = 0; f < 3; f++) add_frame(SYNC, PAY);
    add_frame(8'h00, p4);
    add_frame(SYNC, p5);
    foreach (stim[i]) begin
      tick(stim[i], 1'b1, 1'b0);
      tests_run++;
      if (data_valid !== m_dv || frame_start !== m_fs || locked !== m_locked ||
          parallel_data !== m_pd || sync_err_cnt !== m_err) begin
        tests_failed++;
        $display("FAIL flywheel bit %0d: dv=%b fs=%b lk=%b pd=%h err=%h want dv=%b fs=%b lk=%b pd=%h err=%h",
                 i, data_valid, frame_start, locked, parallel_data, sync_err_cnt, m_dv, m_fs, m_locked, m_pd, m_err);
      end
    end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL flywheel_locked: got %b want 1", locked); end
    tests_run++; if (lock_fall_at != -1) begin tests_failed++; $display("FAIL flywheel_lock_drop: dropped at bit %0d want never", lock_fall_at); end
    tests_run++; if (sync_err_cnt !== 8'h01) begin tests_failed++; $display("FAIL flywheel_err: got %h want 01", sync_err_cnt); end
    tests_run++; if (fs_seen != 3) begin tests_failed++; $display("FAIL flywheel_fs_count: got %0d want 3", fs_seen); end
    tests_run++; if (cap_q.size() != 16) begin tests_failed++; $display("FAIL flywheel_count: got %0d want 16", cap_q.size()); end
    for (int k = 0; k < 4 && k + 8 < cap_q.size(); k++) begin
      tests_run++;
      if (cap_q[k+8] !== p4[31 - 8*k -: 8]) begin
        tests_failed++; $display("FAIL flywheel_sample %0d: got %h want %h", k, cap_q[k+8], p4[31 - 8*k -: 8]);
      end
    end
  endtask

  task automatic test_loss_of_lock();
    do_reset();
    for (int f = 0; f < 3; f++) add_frame(SYNC, PAY);
    add_frame(8'h00, $urandom);
    add_frame(8'h00, $urandom);
    for (int k = 0; k < 5; k++) add_byte(8'h00);
    foreach (stim[i]) begin
      tick(stim[i], 1'b1, 1'b0);
      tests_run++;
      if (data_valid !== m_dv || frame_start !== m_fs || locked !== m_locked ||
          parallel_data !== m_pd || sync_err_cnt !== m_err) begin
        tests_failed++;
        $display("FAIL loss bit %0d: dv=%b fs=%b lk=%b pd=%h err=%h want dv=%b fs=%b lk=%b pd=%h err=%h",
                 i, data_valid, frame_start, locked, parallel_data, sync_err_cnt, m_dv, m_fs, m_locked, m_pd, m_err);
      end
    end
    tests_run++; if (lock_fall_at != 167) begin tests_failed++; $display("FAIL loss_fall: got bit %0d want 167", lock_fall_at); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL loss_locked: got %b want 0", locked); end
    tests_run++; if (sync_err_cnt !== 8'h02) begin tests_failed++; $display("FAIL loss_err: got %h want 02", sync_err_cnt); end
    tests_run++; if (cap_q.size() != 12) begin tests_failed++; $display("FAIL loss_count: got %0d want 12", cap_q.size()); end
  endtask

  task automatic test_false_sync();
    do_reset();
    for (int k = 0; k < 20; k++) stim.push_back(1'($urandom));
    add_frame(SYNC, $urandom);
    add_byte(8'h1A);
    for (int k = 0; k < 3; k++) add_byte(8'h00);
    foreach (stim[i]) begin
      tick(stim[i], 1'b1, 1'b0);
      tests_run++;
      if (data_valid !== m_dv || frame_start !== m_fs || locked !== m_locked ||
          parallel_data !== m_pd || sync_err_cnt !== m_err) begin
        tests_failed++;
        $display("FAIL false_sync bit %0d: dv=%b fs=%b lk=%b pd=%h err=%h want dv=%b fs=%b lk=%b pd=%h err=%h",
                 i, data_valid, frame_start, locked, parallel_data, sync_err_cnt, m_dv, m_fs, m_locked, m_pd, m_err);
      end
    end
    tests_run++; if (cap_q.size() != 0) begin tests_failed++; $display("FAIL false_sync_dv: got %0d pulses want 0", cap_q.size()); end
    tests_run++; if (lock_rise_at != -1) begin tests_failed++; $display("FAIL false_sync_locked: rose at bit %0d want never", lock_rise_at); end
  endtask

  task automatic test_gapped();
    logic [7:0] exp_s;
    do_reset();
    for (int f = 0; f < 3; f++) add_frame(SYNC, PAY);
    foreach (stim[i]) begin
      for (int g = 0; g < 3; g++) begin
        if (g < 2) tick(1'($urandom), 1'b0, 1'b0);
        else tick(stim[i], 1'b1, 1'b0);
        tests_run++;
        if (data_valid !== m_dv || frame_start !== m_fs || locked !== m_locked ||
            parallel_data !== m_pd || sync_err_cnt !== m_err) begin
          tests_failed++;
          $display("FAIL gapped bit %0d.%0d: dv=%b fs=%b lk=%b pd=%h err=%h want dv=%b fs=%b lk=%b pd=%h err=%h",
                   i, g, data_valid, frame_start, locked, parallel_data, sync_err_cnt, m_dv, m_fs, m_locked, m_pd, m_err);
        end
      end
    end
    tests_run++; if (fs_seen != 2) begin tests_failed++; $display("FAIL gapped_fs_count: got %0d want 2", fs_seen); end
    tests_run++; if (cap_q.size() != 8) begin tests_failed++; $display("FAIL gapped_count: got %0d want 8", cap_q.size()); end
    for (int k = 0; k < 8 && k < cap_q.size(); k++) begin
      exp_s = PAY[31 - 8*(k%4) -: 8];
      tests_run++;
      if (cap_q[k] !== exp_s) begin tests_failed++; $display("FAIL gapped_sample %0d: got %h want %h", k, cap_q[k], exp_s); end
    end
  endtask

  task automatic test_reset_resync();
    logic [7:0] exp_s;
    do_reset();
    for (int f = 0; f < 2; f++) add_frame(SYNC, PAY);
    add_byte(SYNC); add_byte(8'h5A); add_byte(8'hC3);
    for (int i = 0; i < 92; i++) tick(stim[i], 1'b1, 1'b0);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL rr_pre_locked: got %b want 1", locked); end
    #2 reset = 1;
    #1;
    model_reset();
    tests_run++; if (parallel_data !== 8'sh00 || data_valid !== 1'b0 || frame_start !== 1'b0 || locked !== 1'b0 || sync_err_cnt !== 8'h00) begin
      tests_failed++; $display("FAIL rr_async_reset: pd=%h dv=%b fs=%b lk=%b err=%h want all 0", parallel_data, data_valid, frame_start, locked, sync_err_cnt);
    end
    @(negedge clk);
    reset = 0;
    clear_obs();
    tick(1'b1, 1'b1, 1'b1);
    tests_run++; if (parallel_data !== 8'sh00 || data_valid !== 1'b0 || frame_start !== 1'b0 || locked !== 1'b0 || sync_err_cnt !== 8'h00) begin
      tests_failed++; $display("FAIL rr_resync: pd=%h dv=%b fs=%b lk=%b err=%h want all 0", parallel_data, data_valid, frame_start, locked, sync_err_cnt);
    end
    clear_obs();
    stim.delete();
    for (int f = 0; f < 2; f++) add_frame(SYNC, PAY);
    foreach (stim[i]) begin
      tick(stim[i], 1'b1, 1'b0);
      tests_run++;
      if (data_valid !== m_dv || frame_start !== m_fs || locked !== m_locked ||
          parallel_data !== m_pd || sync_err_cnt !== m_err) begin
        tests_failed++;
        $display("FAIL reset_resync bit %0d: dv=%b fs=%b lk=%b pd=%h err=%h want dv=%b fs=%b lk=%b pd=%h err=%h",
                 i, data_valid, frame_start, locked, parallel_data, sync_err_cnt, m_dv, m_fs, m_locked, m_pd, m_err);
      end
    end
    tests_run++; if (lock_rise_at != 47) begin tests_failed++; $display("FAIL rr_relock: got bit %0d want 47", lock_rise_at); end
    tests_run++; if (cap_q.size() != 4) begin tests_failed++; $display("FAIL rr_count: got %0d want 4", cap_q.size()); end
    for (int k = 0; k < 4 && k < cap_q.size(); k++) begin
      exp_s = PAY[31 - 8*k -: 8];
      tests_run++;
      if (cap_q[k] !== exp_s) begin tests_failed++; $display("FAIL rr_sample %0d: got %h want %h", k, cap_q[k], exp_s); end
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] s;
    do_reset();
    for (int f = 0; f < 10; f++) begin
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : SYNC;
      add_frame(s, $urandom);
    end
    foreach (stim[i]) begin
      for (int g = $urandom_range(0, 3); g >= 0; g--) begin
        if (g > 0) tick(1'($urandom), 1'b0, 1'b0);
        else tick(stim[i], 1'b1, ($urandom_range(0, 299) == 0));
        tests_run++;
        if (data_valid !== m_dv || frame_start !== m_fs || locked !== m_locked ||
            parallel_data !== m_pd || sync_err_cnt !== m_err) begin
          tests_failed++;
          $display("FAIL random bit %0d: dv=%b fs=%b lk=%b pd=%h err=%h want dv=%b fs=%b lk=%b pd=%h err=%h",
                   i, data_valid, frame_start, locked, parallel_data, sync_err_cnt, m_dv, m_fs, m_locked, m_pd, m_err);
        end
      end
    end
    tests_run++; if (cap_q.size() != m_emit) begin tests_failed++; $display("FAIL random_count: got %0d want %0d", cap_q.size(), m_emit); end
  endtask

  task automatic test_err_saturation();
    do_reset();
    for (int it = 0; it < 130; it++) begin
      stim.delete();
      add_frame(SYNC, 32'h0); add_frame(SYNC, 32'h0);
      add_frame(8'h00, 32'h0); add_frame(8'h00, 32'h0);
      foreach (stim[i]) begin
        tick(stim[i], 1'b1, 1'b0);
        tests_run++;
        if (locked !== m_locked || sync_err_cnt !== m_err || frame_start !== m_fs || data_valid !== m_dv) begin
          tests_failed++;
          $display("FAIL saturation iter %0d bit %0d: lk=%b err=%h fs=%b dv=%b want lk=%b err=%h fs=%b dv=%b",
                   it, i, locked, sync_err_cnt, frame_start, data_valid, m_locked, m_err, m_fs, m_dv);
        end
      end
    end
    tests_run++; if (sync_err_cnt !== 8'hFF) begin tests_failed++; $display("FAIL saturation_final: got %h want ff", sync_err_cnt); end
  endtask

  initial begin
    model_reset();
    clear_obs();
    test_reset();
    test_clean_lock();
    test_flywheel();
    test_loss_of_lock();
    test_false_sync();
    test_gapped();
    test_reset_resync();
    test_random_stream();
    test_err_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
